// File: rtl/alu_acc_pkg.sv
// Shared opcodes and FSM encoding for alu_accumulator.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu_acc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SEXT = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles after start; valid/product are combinational on the last busy cycle.
// Backpressure: start is ignored while busy; no queueing.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_b,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  // The final partial sum is handed out before it is registered so the
  // consumer can commit it on the same edge the multiplier goes idle.
  assign valid    = busy && (cnt == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (valid) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// ALU with 2*WIDTH accumulator; optional multiplier under ALU_ACC_MUL_EN.
// Latency: 1 cycle for all ops; MUL takes WIDTH cycles when compiled in.
// Backpressure: Go is ignored while Busy; no queueing.
module alu_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_b,
  input  logic               Go,
  input  logic [2:0]         Op,
  input  logic [WIDTH-1:0]   Data,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic               Zero
);

  import alu_acc_pkg::*;

  localparam int W2 = 2 * WIDTH;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    alu_res;
  logic             accept;

  assign a      = Data;
  assign b      = Result[WIDTH-1:0];
  assign accept = Go && !Busy;
  assign sum    = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow (set exactly when a < b).
  assign diff   = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = Result;
    case (Op)
      OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB:  alu_res = {{(WIDTH-1){1'b0}}, diff};
      OP_SEXT: alu_res = {{WIDTH{b[WIDTH-1]}}, b};
      OP_OR:   alu_res = {{(W2-1){1'b0}}, |{a, b}};
      OP_AND:  alu_res = {{(W2-1){1'b0}}, &{a, b}};
      // Shift amounts >= W2 shift every bit out, giving 0 with no extra compare.
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, a} << b;
      default: alu_res = Result;
    endcase
  end

`ifdef ALU_ACC_MUL_EN
  state_t         state;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_valid;
  logic [W2-1:0]  mul_product;

  assign mul_start = accept && (Op == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .valid   (mul_valid),
    .product (mul_product)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= S_IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= accept && !mul_start;
          if (mul_start) begin
            state <= S_MUL;
            Busy  <= 1'b1;
          end else if (accept) begin
            Result <= alu_res;
            Zero   <= (alu_res == '0);
          end
        end
        S_MUL: begin
          Done <= mul_valid;
          if (mul_valid || !mul_busy) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
          if (mul_valid) begin
            Result <= mul_product;
            Zero   <= (mul_product == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign Busy = 1'b0;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      Done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
    end else begin
      Done <= accept;
      if (accept) begin
        Result <= alu_res;
        Zero   <= (alu_res == '0);
      end
    end
  end
`endif

endmodule
